// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are issued at the tail, completed by CDB
// broadcasts matching their label, and retired one per cycle from the head.
module reorder_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        issueEN,
    input  logic [4:0]  issueLabel,
    input  logic [4:0]  issueDest,
    input  logic        issueDestEN,
    input  logic        BCEN,
    input  logic [4:0]  BClabel,
    input  logic [31:0] BCdata,
    output logic        full,
    output logic        empty,
    output logic [4:0]  count,
    output logic        commitEN,
    output logic        commitWr,
    output logic [4:0]  commitAddr,
    output logic [4:0]  commitLabel,
    output logic [31:0] commitData
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      head, tail;
    logic [4:0]       count_q;
    logic [DEPTH-1:0] valid, ready, dest_en;
    logic [4:0]       label_q [DEPTH];
    logic [4:0]       dest_q  [DEPTH];
    logic [31:0]      data_q  [DEPTH];

    logic [PW-1:0] head_idx, tail_idx;
    logic          slot_free, do_issue, do_commit, bc_hit;

    assign head_idx  = head[PW-1:0];
    assign tail_idx  = tail[PW-1:0];
    // Same index with opposite wrap bits means the tail has lapped the head.
    assign slot_free = !((head_idx == tail_idx) && (head[PW] != tail[PW]));
    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == 5'd0);
    assign count     = count_q;
    assign do_issue  = issueEN && !full && slot_free;
    assign do_commit = valid[head_idx] && ready[head_idx];
    assign bc_hit    = BCEN && (BClabel != 5'd0);

    always_ff @(posedge clk) begin
        if (RST) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            valid       <= '0;
            ready       <= '0;
            dest_en     <= '0;
            commitEN    <= 1'b0;
            commitWr    <= 1'b0;
            commitAddr  <= '0;
            commitLabel <= '0;
            commitData  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                label_q[i] <= '0;
                dest_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            // Only entries already valid before this edge can capture a result.
            for (int i = 0; i < DEPTH; i++) begin
                if (bc_hit && valid[i] && !ready[i] && label_q[i] == BClabel) begin
                    ready[i]  <= 1'b1;
                    data_q[i] <= BCdata;
                end
            end

            commitEN <= do_commit;
            if (do_commit) begin
                commitWr        <= dest_en[head_idx];
                commitAddr      <= dest_q[head_idx];
                commitLabel     <= label_q[head_idx];
                commitData      <= data_q[head_idx];
                valid[head_idx] <= 1'b0;
                head            <= head + PTR_ONE;
            end

            if (do_issue) begin
                valid[tail_idx]   <= 1'b1;
                ready[tail_idx]   <= !issueDestEN;
                dest_en[tail_idx] <= issueDestEN;
                label_q[tail_idx] <= issueLabel;
                dest_q[tail_idx]  <= issueDest;
                data_q[tail_idx]  <= '0;
                tail              <= tail + PTR_ONE;
            end

            if (do_issue && !do_commit)
                count_q <= count_q + 5'd1;
            else if (do_commit && !do_issue)
                count_q <= count_q - 5'd1;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reorder_buffer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        issueEN = 1'b0, issueDestEN = 1'b0, BCEN = 1'b0;
    logic [4:0]  issueLabel = '0, issueDest = '0, BClabel = '0;
    logic [31:0] BCdata = '0;
    logic        full, empty, commitEN, commitWr;
    logic [4:0]  count, commitAddr, commitLabel;
    logic [31:0] commitData;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .RST(RST), .issueEN(issueEN), .issueLabel(issueLabel),
        .issueDest(issueDest), .issueDestEN(issueDestEN), .BCEN(BCEN),
        .BClabel(BClabel), .BCdata(BCdata), .full(full), .empty(empty),
        .count(count), .commitEN(commitEN), .commitWr(commitWr),
        .commitAddr(commitAddr), .commitLabel(commitLabel), .commitData(commitData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  label;
        logic [4:0]  dest;
        logic        den;
        logic        rdy;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_en = 0, m_wr = 0, started = 0;
    logic [4:0]  m_addr = 0, m_label = 0;
    logic [31:0] m_data = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain in-order queue of outstanding instructions.
    always @(posedge clk) begin
        if (RST) begin
            q.delete();
            m_en = 0; m_wr = 0; m_addr = 0; m_label = 0; m_data = 0;
            started = 1;
        end else begin
            bit was_full;
            was_full = (q.size() == DEPTH);
            m_en = 0;
            if (q.size() > 0 && q[0].rdy) begin
                m_en = 1;
                m_wr = q[0].den; m_addr = q[0].dest;
                m_label = q[0].label; m_data = q[0].data;
                void'(q.pop_front());
            end
            if (BCEN && BClabel != 0)
                foreach (q[i])
                    if (!q[i].rdy && q[i].label == BClabel) begin
                        q[i].rdy = 1;
                        q[i].data = BCdata;
                    end
            if (issueEN && !was_full)
                q.push_back('{issueLabel, issueDest, issueDestEN, !issueDestEN, 32'h0});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("count", count, q.size());
            check("full", full, q.size() == DEPTH);
            check("empty", empty, q.size() == 0);
            check("commitEN", commitEN, m_en);
            check("commitWr", commitWr, m_wr);
            check("commitAddr", commitAddr, m_addr);
            check("commitLabel", commitLabel, m_label);
            check("commitData", commitData, m_data);
        end
    end

    task automatic step(input logic rst, input logic ie, input logic [4:0] il,
                        input logic [4:0] id, input logic ide, input logic bce,
                        input logic [4:0] bcl, input logic [31:0] bcd);
        RST = rst; issueEN = ie; issueLabel = il; issueDest = id; issueDestEN = ide;
        BCEN = bce; BClabel = bcl; BCdata = bcd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [4:0] l, input logic [4:0] d, input logic de);
        step(0, 1, l, d, de, 0, 0, 0);
    endtask

    task automatic bcast(input logic [4:0] l, input logic [31:0] v);
        step(0, 0, 0, 0, 0, 1, l, v);
    endtask

    initial begin
        @(negedge clk); #1;
        // Reset wins over concurrent issue and broadcast.
        step(1, 1, 5'd3, 5'd4, 1, 1, 5'd3, 32'hDEAD);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_commitEN", commitEN, 0);
        check("rst_full", full, 0);

        // Out-of-order completion, in-order retirement.
        issue(1, 4, 1); issue(2, 5, 1); issue(3, 6, 1);
        check("ooo_count3", count, 3);
        bcast(2, 32'h22);
        check("ooo_nocommit_a", commitEN, 0);
        bcast(1, 32'h11);
        check("ooo_nocommit_b", commitEN, 0);
        bcast(3, 32'h33);
        check("ooo_c1_en", commitEN, 1);
        check("ooo_c1_addr", commitAddr, 4);
        check("ooo_c1_data", commitData, 32'h11);
        idle();
        check("ooo_c2_en", commitEN, 1);
        check("ooo_c2_addr", commitAddr, 5);
        check("ooo_c2_data", commitData, 32'h22);
        idle();
        check("ooo_c3_en", commitEN, 1);
        check("ooo_c3_addr", commitAddr, 6);
        check("ooo_c3_data", commitData, 32'h33);
        idle();
        check("ooo_after_en", commitEN, 0);
        check("ooo_after_data_hold", commitData, 32'h33);
        check("ooo_after_empty", empty, 1);

        // Fill to capacity, refused issue, then one retirement.
        for (int i = 1; i <= DEPTH; i++) issue(5'(i), 5'(i + 8), 1);
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH);
        issue(5'd20, 5'd20, 1);
        check("fill_refused_count", count, DEPTH);
        bcast(1, 32'hAA);
        check("fill_still_full", full, 1);
        idle();
        check("fill_commit_en", commitEN, 1);
        check("fill_after_commit_count", count, DEPTH - 1);
        check("fill_after_commit_full", full, 0);

        // Simultaneous issue and commit keeps count at 5.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) issue(5'(i), 5'(i), 1);
        bcast(1, 32'h51);
        issue(5'd9, 5'd9, 1);
        check("same_edge_count", count, 5);
        check("same_edge_commit", commitEN, 1);

        // No-result entry retires on its own; label-0 broadcast is inert.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        issue(5'd7, 5'd12, 0);
        check("nodest_wait", commitEN, 0);
        step(0, 1, 5'd0, 5'd3, 1, 1, 5'd0, 32'hBEEF);
        check("nodest_en", commitEN, 1);
        check("nodest_wr", commitWr, 0);
        check("nodest_data", commitData, 0);
        bcast(0, 32'hCAFE);
        bcast(0, 32'hCAFE);
        idle();
        check("lbl0_count", count, 1);
        check("lbl0_en", commitEN, 0);

        // Twenty triples walk the pointers around twice.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            issue(5'((i % 31) + 1), 5'(i), 1);
            bcast(5'((i % 31) + 1), 32'h100 + i);
            idle();
            check("wrap_en", commitEN, 1);
            check("wrap_data", commitData, 32'h100 + i);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
